// File: rtl/sir_pkg.sv
// Shared state encoding and reset-seed constants for the per-person epidemic agent.
package sir_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_S = 3'd0,
    ST_E = 3'd1,
    ST_I = 3'd2,
    ST_R = 3'd3,
    ST_D = 3'd4
  } sir_state_e;

  // An agent may only be seeded as susceptible or as patient zero.
  localparam int INIT_SUSCEPTIBLE = 0;
  localparam int INIT_INFECTED    = 2;

  function automatic bit init_state_legal(input int s);
    return (s == INIT_SUSCEPTIBLE) || (s == INIT_INFECTED);
  endfunction

endpackage

// File: rtl/sir_day_counter.sv
// Saturating day counter with synchronous clear/increment and a compare
// against a limit supplied at runtime by the owning state machine.
module sir_day_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/sir_agent.sv
// One simulated person stepping through S/E/I/R (and D when SIR_MORTALITY_EN
// is defined) once per simulation-day tick.
module sir_agent
  import sir_pkg::*;
#(
  parameter int NBR             = 4,
  parameter int INCUB_DAYS      = 3,
  parameter int INFECT_MIN_DAYS = 2,
  parameter int IMMUNE_DAYS     = 30,
  parameter int INIT_STATE      = 0,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NBR-1:0]     nbr_inf,
  input  logic [NBR-1:0]     inf_rnd,
  input  logic               rec_rnd,
  input  logic               mort_rnd,
  output logic [STATE_W-1:0] state,
  output logic               infectious,
  output logic [CNT_W-1:0]   day_cnt,
  output logic               new_case
);

  localparam logic [STATE_W-1:0] RST_STATE =
    init_state_legal(INIT_STATE) ? STATE_W'(INIT_STATE) : ST_S;
  localparam logic [CNT_W-1:0] INCUB_LIM  = CNT_W'((INCUB_DAYS  > 0) ? INCUB_DAYS  - 1 : 0);
  localparam logic [CNT_W-1:0] IMMUNE_LIM = CNT_W'((IMMUNE_DAYS > 0) ? IMMUNE_DAYS - 1 : 0);
  localparam logic [31:0]      MIN_DAYS   = 32'(INFECT_MIN_DAYS);

  logic [STATE_W-1:0] state_q, state_d;
  logic               new_case_q, new_case_d;
  logic               cnt_clr, cnt_inc, cnt_term;
  logic [CNT_W-1:0]   cnt_limit;
  logic               exposed, mort_hit;

`ifdef SIR_MORTALITY_EN
  assign mort_hit = mort_rnd;
`else
  logic mort_unused;
  assign mort_unused = mort_rnd;
  assign mort_hit    = 1'b0;
`endif

  assign exposed   = |(nbr_inf & inf_rnd);
  assign cnt_limit = (state_q == ST_R) ? IMMUNE_LIM : INCUB_LIM;

  sir_day_counter #(.CNT_W(CNT_W)) u_day_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .limit_i (cnt_limit),
    .cnt_o   (day_cnt),
    .term_o  (cnt_term)
  );

  always_comb begin
    state_d    = state_q;
    new_case_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_S: begin
          cnt_clr = 1'b1;
          if (exposed) begin
            state_d    = (INCUB_DAYS == 0) ? ST_I : ST_E;
            new_case_d = 1'b1;
          end
        end
        ST_E: begin
          if (cnt_term) begin
            state_d = ST_I;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_I: begin
          if (mort_hit) begin
            state_d = ST_D;
            cnt_clr = 1'b1;
          end else if ((32'(day_cnt) >= MIN_DAYS) && rec_rnd) begin
            state_d = ST_R;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_R: begin
          if (IMMUNE_DAYS == 0) begin
            cnt_clr = 1'b1;
          end else if (cnt_term) begin
            state_d = ST_S;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
`ifdef SIR_MORTALITY_EN
        ST_D: begin
        end
`endif
        // Corrupted codes (and D when mortality is compiled out) recover to S.
        default: begin
          state_d = ST_S;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      new_case_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      new_case_q <= new_case_d;
    end
  end

  assign state      = state_q;
  assign infectious = (state_q == ST_I);
  assign new_case   = new_case_q;

endmodule

// File: tb/tb_sir_agent.sv
// Self-checking bench: a default agent (A) and a patient-zero agent (B) with
// permanent immunity and a 2-bit day counter, both compared against a day-level model.
module tb_sir_agent;

`ifdef SIR_MORTALITY_EN
  localparam bit MORT_EN = 1'b1;
`else
  localparam bit MORT_EN = 1'b0;
`endif

  localparam int A_INCUB = 3, A_MIN = 2, A_IMMUNE = 30, A_MAX = 255;
  localparam int B_INCUB = 3, B_MIN = 2, B_IMMUNE = 0,  B_MAX = 3;

  logic       clk = 1'b0;
  logic       rst, tick, recRnd, mortRnd;
  logic [3:0] nbrInf, infRnd;
  logic [2:0] stateA, stateB;
  logic       infA, infB, ncA, ncB;
  logic [7:0] dayA;
  logic [1:0] dayB;

  int   checks = 0;
  int   failures = 0;
  int   mAst, mAday, mBst, mBday;
  logic mAnc, mBnc;

  always #5 clk = ~clk;

  sir_agent u_dutA (
    .clk(clk), .rst(rst), .tick(tick), .nbr_inf(nbrInf), .inf_rnd(infRnd),
    .rec_rnd(recRnd), .mort_rnd(mortRnd), .state(stateA), .infectious(infA),
    .day_cnt(dayA), .new_case(ncA)
  );

  sir_agent #(.INIT_STATE(2), .IMMUNE_DAYS(0), .CNT_W(2)) u_dutB (
    .clk(clk), .rst(rst), .tick(tick), .nbr_inf(nbrInf), .inf_rnd(infRnd),
    .rec_rnd(recRnd), .mort_rnd(mortRnd), .state(stateB), .infectious(infB),
    .day_cnt(dayB), .new_case(ncB)
  );

  // One simulation day for a person, in state codes S=0 E=1 I=2 R=3 D=4.
  function automatic void stepModel(
    input int incub, input int minD, input int immune, input int maxCnt,
    input int st, input int day, input logic tk, input logic [3:0] nb,
    input logic [3:0] inf, input logic rec, input logic mort,
    output int nst, output int nday, output logic nc);
    nst  = st;
    nday = day;
    nc   = 1'b0;
    if (!tk) return;
    case (st)
      0: begin
        nday = 0;
        if ((nb & inf) != 4'b0) begin
          nst = (incub == 0) ? 2 : 1;
          nc  = 1'b1;
        end
      end
      1: if (day == incub - 1) begin nst = 2; nday = 0; end
         else nday = (day + 1 > maxCnt) ? maxCnt : day + 1;
      2: if (MORT_EN && mort) begin nst = 4; nday = 0; end
         else if (day >= minD && rec) begin nst = 3; nday = 0; end
         else nday = (day + 1 > maxCnt) ? maxCnt : day + 1;
      3: if (immune == 0) nday = 0;
         else if (day == immune - 1) begin nst = 0; nday = 0; end
         else nday = (day + 1 > maxCnt) ? maxCnt : day + 1;
      4: if (!MORT_EN) begin nst = 0; nday = 0; end
      default: begin nst = 0; nday = 0; end
    endcase
  endfunction

  task automatic resetModels();
    mAst = 0; mAday = 0; mAnc = 1'b0;
    mBst = 2; mBday = 0; mBnc = 1'b0;
  endtask

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".A.state"}, stateA, mAst);
    expectEq({tag, ".A.day"},   dayA,   mAday);
    expectEq({tag, ".A.inf"},   infA,   (mAst == 2) ? 1 : 0);
    expectEq({tag, ".A.nc"},    ncA,    mAnc);
    expectEq({tag, ".B.state"}, stateB, mBst);
    expectEq({tag, ".B.day"},   dayB,   mBday);
    expectEq({tag, ".B.inf"},   infB,   (mBst == 2) ? 1 : 0);
    expectEq({tag, ".B.nc"},    ncB,    mBnc);
  endtask

  task automatic applyStimulus(input logic tk, input logic [3:0] nb, input logic [3:0] inf,
                               input logic rec, input logic mort, input string tag);
    tick = tk; nbrInf = nb; infRnd = inf; recRnd = rec; mortRnd = mort;
    @(posedge clk);
    stepModel(A_INCUB, A_MIN, A_IMMUNE, A_MAX, mAst, mAday, tk, nb, inf, rec, mort,
              mAst, mAday, mAnc);
    stepModel(B_INCUB, B_MIN, B_IMMUNE, B_MAX, mBst, mBday, tk, nb, inf, rec, mort,
              mBst, mBday, mBnc);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; nbrInf = '0; infRnd = '0; recRnd = 1'b0; mortRnd = 1'b0;
    resetModels();
    #12;
    checkOutput("reset");
    expectEq("reset_pz_infectious", infB, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_reset");

    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, "pz_early_rec");
    expectEq("pz_early_rec_state", stateB, 2);
    expectEq("pz_early_rec_day", dayB, 1);

    applyStimulus(1'b1, 4'b0100, 4'b1000, 1'b0, 1'b0, "miss");
    expectEq("miss_state", stateA, 0);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, "expose");
    expectEq("expose_state", stateA, 1);
    expectEq("expose_nc", ncA, 1);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, "idle");
    expectEq("idle_nc", ncA, 0);
    expectEq("idle_state", stateA, 1);

    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "e1");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "e2");
    expectEq("e2_state", stateA, 1);
    expectEq("e2_day", dayA, 2);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "e3");
    expectEq("e3_state", stateA, 2);
    expectEq("e3_day", dayA, 0);
    expectEq("pz_sat_day", dayB, 3);

    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "i1");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "i2");
    expectEq("i2_day", dayA, 2);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, "mort_vs_rec");
`ifdef SIR_MORTALITY_EN
    expectEq("mort_vs_rec_state", stateA, 4);
`else
    expectEq("mort_vs_rec_state", stateA, 3);
`endif

    for (int i = 0; i < 29; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, "immune");
    end
`ifdef SIR_MORTALITY_EN
    expectEq("dead_persists", stateA, 4);
`else
    expectEq("immune29_state", stateA, 3);
    expectEq("immune29_day", dayA, 29);
`endif
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "immune30");
`ifdef SIR_MORTALITY_EN
    expectEq("immune30_state", stateA, 4);
`else
    expectEq("immune30_state", stateA, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom & $urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), "random");
    end
`ifdef SIR_MORTALITY_EN
    expectEq("pz_final_state", stateB, 4);
`else
    expectEq("pz_permanent_immunity", stateB, 3);
`endif
    expectEq("pz_final_day", dayB, 0);

    rst = 1'b1;
    #1;
    rst = 1'b0;
    resetModels();
    checkOutput("rst_clear");
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, "expose2");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "e_mid");
    expectEq("e_mid_state", stateA, 1);
    expectEq("e_mid_day", dayA, 1);
    #2;
    rst = 1'b1;
    #1;
    expectEq("async_rst_state", stateA, 0);
    expectEq("async_rst_day", dayA, 0);
    expectEq("async_rst_pz_state", stateB, 2);
    resetModels();
    checkOutput("async_rst");
    #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
